lives_game_fsm: RTL and testbench

Game-state and life manager that sits directly downstream of the game controller. It consumes the per-pixel smiley/explosion collision level and the two BCD score digits. It runs the IDLE / PLAY / INVULN / GAME_OVER / WIN state machine and tracks remaining lives with a post-hit invulnerability window. It drives the lives digit, state flags and a smiley blink enable to the display path.

---
 rtl/lives_game_fsm.sv | 183 ++++++++++++++++++
 tb/tb_lives_game_fsm.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lives_game_fsm.sv
// Game-state and life manager: IDLE/PLAY/INVULN/GAME_OVER/WIN sequencing,
// life counting with a post-hit invulnerability window and smiley blink.
module lives_game_fsm #(
    parameter int unsigned START_LIVES   = 3,
    parameter int unsigned INVULN_FRAMES = 60,
    parameter int unsigned WIN_SCORE     = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       collision_lostLife,
    input  logic [3:0] score_top,
    input  logic [3:0] score_bottom,
    input  logic       start_pressed,
    output logic [2:0] lives,
    output logic       play_enable,
    output logic       invulnerable,
    output logic       blink,
    output logic       life_lost_pulse,
    output logic       game_over,
    output logic       game_won
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_INVULN    = 3'd2,
        ST_GAME_OVER = 3'd3,
        ST_WIN       = 3'd4
    } state_t;

    localparam logic [2:0] START_LIVES_V   = 3'(START_LIVES);
    localparam logic [7:0] INVULN_FRAMES_V = 8'(INVULN_FRAMES);
    localparam logic [6:0] WIN_SCORE_V     = 7'(WIN_SCORE);

    function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] units);
        return ({3'd0, tens} * 7'd10) + {3'd0, units};
    endfunction

    state_t     state;
    logic [7:0] inv_cnt;
    logic [2:0] frame_cnt;
    logic       hit_seen;
    logic       start_prev;
    logic       start_edge;

    logic [6:0] score_value;
    logic       win_now;
    logic [2:0] frame_cnt_inc;

    assign score_value   = bcd_to_bin(score_top, score_bottom);
    assign win_now       = (score_value >= WIN_SCORE_V);
    assign frame_cnt_inc = frame_cnt + 3'd1;

    // Start key edge detector; the edge itself is registered, so a press
    // reaches the state register two clocks after the key rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_prev <= 1'b0;
            start_edge <= 1'b0;
        end else begin
            start_prev <= start_pressed;
            start_edge <= start_pressed & ~start_prev;
        end
    end

    // Game state machine with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            lives           <= START_LIVES_V;
            inv_cnt         <= 8'd0;
            frame_cnt       <= 3'd0;
            hit_seen        <= 1'b0;
            play_enable     <= 1'b0;
            invulnerable    <= 1'b0;
            blink           <= 1'b0;
            life_lost_pulse <= 1'b0;
            game_over       <= 1'b0;
            game_won        <= 1'b0;
        end else begin
            life_lost_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    lives    <= START_LIVES_V;
                    hit_seen <= 1'b0;
                    if (start_edge) begin
                        state       <= ST_PLAY;
                        play_enable <= 1'b1;
                    end else begin
                        state       <= ST_IDLE;
                        play_enable <= 1'b0;
                    end
                end

                ST_PLAY: begin
                    if (startOfFrame) begin
                        if (hit_seen) begin
                            // Hit beats a win decided in the same frame.
                            lives           <= lives - 3'd1;
                            life_lost_pulse <= 1'b1;
                            hit_seen        <= 1'b0;
                            if (lives <= 3'd1) begin
                                state       <= ST_GAME_OVER;
                                play_enable <= 1'b0;
                                game_over   <= 1'b1;
                            end else begin
                                state        <= ST_INVULN;
                                inv_cnt      <= INVULN_FRAMES_V;
                                frame_cnt    <= 3'd0;
                                invulnerable <= 1'b1;
                                blink        <= 1'b0;
                            end
                        end else if (win_now) begin
                            state       <= ST_WIN;
                            hit_seen    <= 1'b0;
                            play_enable <= 1'b0;
                            game_won    <= 1'b1;
                        end else begin
                            // A collision on the frame boundary belongs to the next frame.
                            hit_seen <= collision_lostLife;
                        end
                    end else begin
                        hit_seen <= hit_seen | collision_lostLife;
                    end
                end

                ST_INVULN: begin
                    hit_seen <= 1'b0;
                    if (startOfFrame) begin
                        inv_cnt   <= inv_cnt - 8'd1;
                        frame_cnt <= frame_cnt_inc;
                        if (win_now) begin
                            state        <= ST_WIN;
                            play_enable  <= 1'b0;
                            invulnerable <= 1'b0;
                            blink        <= 1'b0;
                            game_won     <= 1'b1;
                        end else if (inv_cnt <= 8'd1) begin
                            state        <= ST_PLAY;
                            invulnerable <= 1'b0;
                            blink        <= 1'b0;
                        end else begin
                            blink <= frame_cnt_inc[2];
                        end
                    end else begin
                        inv_cnt <= inv_cnt;
                    end
                end

                ST_GAME_OVER, ST_WIN: begin
                    hit_seen <= 1'b0;
                    if (start_edge) begin
                        state        <= ST_IDLE;
                        lives        <= START_LIVES_V;
                        play_enable  <= 1'b0;
                        invulnerable <= 1'b0;
                        blink        <= 1'b0;
                        game_over    <= 1'b0;
                        game_won     <= 1'b0;
                    end else begin
                        state <= state;
                    end
                end

                default: begin
                    // Unreachable encodings recover to a clean idle.
                    state        <= ST_IDLE;
                    lives        <= START_LIVES_V;
                    inv_cnt      <= 8'd0;
                    frame_cnt    <= 3'd0;
                    hit_seen     <= 1'b0;
                    play_enable  <= 1'b0;
                    invulnerable <= 1'b0;
                    blink        <= 1'b0;
                    game_over    <= 1'b0;
                    game_won     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lives_game_fsm.sv
// Directed bench for lives_game_fsm: a per-cycle vector table plus
// hand-written multi-frame sequences for invulnerability, game over and reset.
module tb_lives_game_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       startOfFrame;
    logic       collision_lostLife;
    logic [3:0] score_top;
    logic [3:0] score_bottom;
    logic       start_pressed;
    logic [2:0] lives;
    logic       play_enable;
    logic       invulnerable;
    logic       blink;
    logic       life_lost_pulse;
    logic       game_over;
    logic       game_won;

    int tests_run = 0;
    int tests_failed = 0;
    int pulse_total = 0;

    lives_game_fsm #(.START_LIVES(3), .INVULN_FRAMES(60), .WIN_SCORE(50)) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .collision_lostLife(collision_lostLife), .score_top(score_top),
        .score_bottom(score_bottom), .start_pressed(start_pressed),
        .lives(lives), .play_enable(play_enable), .invulnerable(invulnerable),
        .blink(blink), .life_lost_pulse(life_lost_pulse),
        .game_over(game_over), .game_won(game_won)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (life_lost_pulse === 1'b1) pulse_total++;

    // {lives, play_enable, invulnerable, blink, life_lost_pulse, game_over, game_won}
    wire [8:0] obs = {lives, play_enable, invulnerable, blink, life_lost_pulse, game_over, game_won};

    function automatic logic [8:0] ex(int l, bit pe, bit inv, bit bl, bit pu, bit go, bit gw);
        return {3'(l), pe, inv, bl, pu, go, gw};
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b want %b (lives,pe,inv,blink,pulse,over,won)", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sof_pulse();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic frames(input int n, input int len);
        for (int f = 0; f < n; f++) begin
            repeat (len - 1) tick();
            sof_pulse();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        startOfFrame = 1'b0; collision_lostLife = 1'b0; start_pressed = 1'b0;
        score_top = 4'd0; score_bottom = 4'd0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic do_start();
        start_pressed = 1'b1;
        tick();
        tick();
        start_pressed = 1'b0;
        tick();
    endtask

    task automatic hit();
        collision_lostLife = 1'b1;
        tick();
        collision_lostLife = 1'b0;
        sof_pulse();
    endtask

    typedef struct {
        logic       start;
        logic       sof;
        logic       coll;
        logic [3:0] top;
        logic [3:0] bot;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(bit s, bit f, bit c, int t, int b, logic [8:0] e);
        vec_t v;
        v.start = s; v.sof = f; v.coll = c; v.top = 4'(t); v.bot = 4'(b); v.exp = e;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(1, 0, 0, 0, 0, ex(3, 0, 0, 0, 0, 0, 0));
        vecs[1]  = mk(1, 0, 0, 0, 0, ex(3, 1, 0, 0, 0, 0, 0));
        vecs[2]  = mk(0, 0, 1, 0, 0, ex(3, 1, 0, 0, 0, 0, 0));
        vecs[3]  = mk(0, 0, 0, 0, 0, ex(3, 1, 0, 0, 0, 0, 0));
        vecs[4]  = mk(0, 1, 0, 0, 0, ex(2, 1, 1, 0, 1, 0, 0));
        vecs[5]  = mk(0, 0, 0, 0, 0, ex(2, 1, 1, 0, 0, 0, 0));
        vecs[6]  = mk(0, 0, 1, 0, 0, ex(2, 1, 1, 0, 0, 0, 0));
        vecs[7]  = mk(0, 1, 1, 0, 0, ex(2, 1, 1, 0, 0, 0, 0));
        vecs[8]  = mk(0, 0, 0, 5, 0, ex(2, 1, 1, 0, 0, 0, 0));
        vecs[9]  = mk(0, 1, 0, 5, 0, ex(2, 0, 0, 0, 0, 0, 1));
        vecs[10] = mk(1, 0, 0, 5, 0, ex(2, 0, 0, 0, 0, 0, 1));
        vecs[11] = mk(1, 0, 0, 5, 0, ex(3, 0, 0, 0, 0, 0, 0));
        vecs[12] = mk(0, 0, 0, 0, 0, ex(3, 0, 0, 0, 0, 0, 0));
        vecs[13] = mk(1, 0, 0, 0, 0, ex(3, 0, 0, 0, 0, 0, 0));
        vecs[14] = mk(1, 0, 0, 0, 0, ex(3, 1, 0, 0, 0, 0, 0));
        vecs[15] = mk(0, 1, 0, 4, 9, ex(3, 1, 0, 0, 0, 0, 0));
        vecs[16] = mk(0, 1, 0, 5, 0, ex(3, 0, 0, 0, 0, 0, 1));

        // Reset state and the per-cycle vector table
        do_reset();
        check("reset_state", obs, ex(3, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 17; i++) begin
            start_pressed = vecs[i].start;
            startOfFrame = vecs[i].sof;
            collision_lostLife = vecs[i].coll;
            score_top = vecs[i].top;
            score_bottom = vecs[i].bot;
            tick();
            check($sformatf("vec%0d", i), obs, vecs[i].exp);
        end
        startOfFrame = 1'b0; collision_lostLife = 1'b0; start_pressed = 1'b0;

        // Long collision in one frame, then the full invulnerability window
        do_reset();
        do_start();
        check("a_play", obs, ex(3, 1, 0, 0, 0, 0, 0));
        pulse_total = 0;
        collision_lostLife = 1'b1;
        repeat (200) tick();
        collision_lostLife = 1'b0;
        repeat (50) tick();
        check_int("a_no_pulse_before_sof", pulse_total, 0);
        sof_pulse();
        check("a_hit", obs, ex(2, 1, 1, 0, 1, 0, 0));
        tick();
        check("a_pulse_one_clk", obs, ex(2, 1, 1, 0, 0, 0, 0));
        for (int k = 1; k <= 60; k++) begin
            collision_lostLife = k[0];
            repeat (4) tick();
            sof_pulse();
            if (k < 60)
                check($sformatf("a_inv_f%0d", k), obs, ex(2, 1, 1, ((k % 8) >= 4), 0, 0, 0));
            else
                check("a_back_to_play", obs, ex(2, 1, 0, 0, 0, 0, 0));
        end
        collision_lostLife = 1'b0;
        repeat (3) tick();
        check_int("a_single_pulse", pulse_total, 1);

        // Three hits to game over, last one coincides with a winning score
        do_reset();
        do_start();
        hit();
        check("b_hit1", obs, ex(2, 1, 1, 0, 1, 0, 0));
        frames(60, 3);
        check("b_play2", obs, ex(2, 1, 0, 0, 0, 0, 0));
        hit();
        check("b_hit2", obs, ex(1, 1, 1, 0, 1, 0, 0));
        frames(60, 3);
        score_top = 4'd5; score_bottom = 4'd0;
        hit();
        check("b_game_over", obs, ex(0, 0, 0, 0, 1, 1, 0));
        frames(3, 4);
        check("b_frozen", obs, ex(0, 0, 0, 0, 0, 1, 0));
        start_pressed = 1'b1;
        tick();
        tick();
        check("b_idle", obs, ex(3, 0, 0, 0, 0, 0, 0));
        start_pressed = 1'b0;
        score_top = 4'd0; score_bottom = 4'd0;

        // Hit and winning score in the same frame: hit first, win next frame
        do_reset();
        do_start();
        score_top = 4'd5; score_bottom = 4'd0;
        hit();
        check("c_hit_over_win", obs, ex(2, 1, 1, 0, 1, 0, 0));
        frames(1, 3);
        check("c_win_in_invuln", obs, ex(2, 0, 0, 0, 0, 0, 1));
        score_top = 4'd0; score_bottom = 4'd0;

        // Asynchronous reset in the middle of invulnerability
        do_reset();
        do_start();
        hit();
        frames(30, 3);
        check("d_mid_invuln", obs, ex(2, 1, 1, 1, 0, 0, 0));
        #2 reset = 1'b1;
        #1 check("d_async_reset", obs, ex(3, 0, 0, 0, 0, 0, 0));
        tick();
        #2 reset = 1'b0;
        collision_lostLife = 1'b1;
        frames(5, 4);
        collision_lostLife = 1'b0;
        check("d_stays_idle", obs, ex(3, 0, 0, 0, 0, 0, 0));
        do_start();
        check("d_restart", obs, ex(3, 1, 0, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
